// File: rtl/mem_bus_pkg.sv
// Shared constants for the CPU memory-bus router: FSM encoding, wait-counter width and
// the default region map (RAM, CGA, BIOS).
package mem_bus_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic [19:0] RamBase  = 20'h00000;
  localparam logic [19:0] RamMask  = 20'hC0000;
  localparam logic [19:0] CgaBase  = 20'hB8000;
  localparam logic [19:0] CgaMask  = 20'hFE000;
  localparam logic [19:0] BiosBase = 20'hF0000;
  localparam logic [19:0] BiosMask = 20'hFE000;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational table-driven address decoder; the lowest-numbered matching enabled region wins.
module mem_region_decode
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned NREG   = 4,
  parameter int unsigned IDX_W  = (NREG > 1) ? $clog2(NREG) : 1,
  parameter logic [NREG-1:0]        REG_EN   = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = '0,
  parameter logic [NREG*WAIT_W-1:0] REG_WAIT = '0,
  parameter logic [NREG-1:0]        REG_RO   = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              ro_o,
  output logic [WAIT_W-1:0] wait_o
);

  // Scan from the top down so the lowest matching index overwrites the others.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (REG_EN[i] &&
          ((addr_i & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W])) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

  assign ro_o   = REG_RO[idx_o];
  assign wait_o = REG_WAIT[idx_o*WAIT_W +: WAIT_W];

endmodule

// File: rtl/mem_bus_router.sv
// CPU-to-memory-region router with registered req/ready handshake, per-region wait states,
// write protection and bus-error reporting.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 4,
  parameter logic [NREG-1:0]        REG_EN   = 4'b0111,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = {20'h0, BiosBase, CgaBase, RamBase},
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = {20'h0, BiosMask, CgaMask, RamMask},
  parameter logic [NREG*WAIT_W-1:0] REG_WAIT = {4'd0, 4'd0, 4'd1, 4'd0},
  parameter logic [NREG-1:0]        REG_RO   = 4'b0100
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   cpu_req_i,
  input  logic                   cpu_we_i,
  input  logic [ADDR_W-1:0]      cpu_address_i,
  input  logic [DATA_W-1:0]      cpu_wdata_i,
  output logic [DATA_W-1:0]      cpu_rdata_o,
  output logic                   cpu_ready_o,
  output logic [ADDR_W-1:0]      mem_address_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  output logic [NREG-1:0]        mem_sel_o,
  output logic [NREG-1:0]        mem_we_o,
  input  logic [NREG*DATA_W-1:0] mem_rdata_i,
  output logic                   bus_err_o,
  output logic [ADDR_W-1:0]      err_address_o
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic              ro;
  logic [WAIT_W-1:0] wait_cycles;
  logic [NREG-1:0]   onehot;

  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;

  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .NREG     (NREG),
    .IDX_W    (IDX_W),
    .REG_EN   (REG_EN),
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK),
    .REG_WAIT (REG_WAIT),
    .REG_RO   (REG_RO)
  ) u_decode (
    .addr_i (cpu_address_i),
    .hit_o  (hit),
    .idx_o  (idx),
    .ro_o   (ro),
    .wait_o (wait_cycles)
  );

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      wr_q          <= 1'b0;
      cpu_rdata_o   <= '1;
      cpu_ready_o   <= 1'b0;
      mem_address_o <= '0;
      mem_wdata_o   <= '0;
      mem_sel_o     <= '0;
      mem_we_o      <= '0;
      bus_err_o     <= 1'b0;
      err_address_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_req_i) begin
            if (hit) begin
              mem_address_o <= cpu_address_i;
              mem_wdata_o   <= cpu_wdata_i;
              mem_sel_o     <= onehot;
              mem_we_o      <= (cpu_we_i && !ro) ? onehot : '0;
              cnt_q         <= wait_cycles;
              idx_q         <= idx;
              wr_q          <= cpu_we_i;
              // Protected writes run the normal access timing but raise an error.
              if (cpu_we_i && ro) begin
                bus_err_o     <= 1'b1;
                err_address_o <= cpu_address_i;
              end
              state_q <= StAccess;
            end else begin
              cpu_rdata_o   <= '1;
              cpu_ready_o   <= 1'b1;
              bus_err_o     <= 1'b1;
              err_address_o <= cpu_address_i;
              state_q       <= StDone;
            end
          end
        end
        StAccess: begin
          mem_we_o  <= '0;
          bus_err_o <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cpu_rdata_o <= wr_q ? '1 : mem_rdata_i[idx_q*DATA_W +: DATA_W];
            cpu_ready_o <= 1'b1;
            mem_sel_o   <= '0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          cpu_ready_o <= 1'b0;
          bus_err_o   <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: stimulus pushes expected completions, a negedge
// monitor pops and compares each cpu_ready pulse.
module tb_mem_bus_router;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req;
  logic                   we;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W-1:0]      rdata;
  logic                   ready;
  logic [ADDR_W-1:0]      mem_address;
  logic [DATA_W-1:0]      mem_wdata;
  logic [NREG-1:0]        mem_sel;
  logic [NREG-1:0]        mem_we;
  logic [NREG*DATA_W-1:0] mem_rdata;
  logic                   bus_err;
  logic [ADDR_W-1:0]      err_address;

  always #5 clk = ~clk;

  mem_bus_router #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .REG_EN   (4'b1111),
    .REG_BASE ({20'h40000, 20'hF0000, 20'hB8000, 20'h00000}),
    .REG_MASK ({20'hC0000, 20'hFE000, 20'hFE000, 20'hC0000}),
    .REG_WAIT ({4'd15, 4'd0, 4'd1, 4'd0}),
    .REG_RO   (4'b0100)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .cpu_req_i     (req),
    .cpu_we_i      (we),
    .cpu_address_i (addr),
    .cpu_wdata_i   (wdata),
    .cpu_rdata_o   (rdata),
    .cpu_ready_o   (ready),
    .mem_address_o (mem_address),
    .mem_wdata_o   (mem_wdata),
    .mem_sel_o     (mem_sel),
    .mem_we_o      (mem_we),
    .mem_rdata_i   (mem_rdata),
    .bus_err_o     (bus_err),
    .err_address_o (err_address)
  );

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] eaddr;
    int                cyc;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Per-transaction activity observed on the memory side
  int              we_cycles;
  logic [NREG-1:0] we_last;
  logic [ADDR_W-1:0] we_addr;
  logic [DATA_W-1:0] we_data;
  logic [NREG-1:0] sel_or;
  int              err_pulses;

  logic [ADDR_W-1:0] model_eaddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we != '0) begin
      we_cycles++;
      we_last = mem_we;
      we_addr = mem_address;
      we_data = mem_wdata;
    end
    sel_or = sel_or | mem_sel;
    if (bus_err) err_pulses++;
    if (ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("ready_bus_err", 32'(bus_err), 32'(e.err));
        chk("err_address", 32'(err_address), 32'(e.eaddr));
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        done_cnt++;
      end
    end
  end

  task automatic clear_obs();
    we_cycles  = 0;
    we_last    = '0;
    we_addr    = '0;
    we_data    = '0;
    sel_or     = '0;
    err_pulses = 0;
  endtask

  // Issue one access. b2b: previous access just completed with req held, so the DUT spends
  // one extra cycle in DONE before sampling. keep: leave req high afterwards.
  task automatic access(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int lat, input logic [DATA_W-1:0] exp_rd, input logic exp_err,
                        input logic err_now, input bit b2b, input bit keep);
    exp_t e;
    int   start;
    if (err_now) model_eaddr = a;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.eaddr = model_eaddr;
    e.cyc   = cyc + 1 + lat + (b2b ? 1 : 0);
    sb.push_back(e);
    start = done_cnt;
    for (int i = 0; i < 40 && done_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt == start) chk("ready_timeout", 32'(done_cnt), 32'(start + 1));
    if (!keep) begin
      req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    mem_rdata = {8'h96, 8'hE7, 8'hC3, 8'h5A};
    clear_obs();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdata", 32'(rdata), 32'hFF);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sel", 32'(mem_sel), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_err_address", 32'(err_address), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // 1: RAM read, no wait states
    clear_obs();
    access(1'b0, 20'h01234, 8'h00, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_sel", 32'(sel_or), 32'b0001);
    chk("t1_err_pulses", 32'(err_pulses), 32'd0);
    chk("t1_we_cycles", 32'(we_cycles), 32'd0);

    // 2: CGA write, one wait state
    clear_obs();
    access(1'b1, 20'hB8010, 8'h41, 2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_we_cycles", 32'(we_cycles), 32'd1);
    chk("t2_we", 32'(we_last), 32'b0010);
    chk("t2_we_addr", 32'(we_addr), 32'hB8010);
    chk("t2_we_data", 32'(we_data), 32'h41);
    chk("t2_sel", 32'(sel_or), 32'b0010);

    // 3: write to protected BIOS
    clear_obs();
    access(1'b1, 20'hF0005, 8'h00, 1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_we_cycles", 32'(we_cycles), 32'd0);
    chk("t3_err_pulses", 32'(err_pulses), 32'd1);
    chk("t3_sel", 32'(sel_or), 32'b0100);

    // 4: unmapped read
    clear_obs();
    access(1'b0, 20'h80000, 8'h00, 0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_sel", 32'(sel_or), 32'd0);
    chk("t4_err_pulses", 32'(err_pulses), 32'd1);

    // 5: reset in the middle of a 15-wait read
    clear_obs();
    req  = 1'b1;
    we   = 1'b0;
    addr = 20'h40000;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_sel_mid", 32'(mem_sel), 32'b1000);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_ready", 32'(ready), 32'd0);
    chk("t5_sel", 32'(mem_sel), 32'd0);
    chk("t5_we", 32'(mem_we), 32'd0);
    chk("t5_err_address", 32'(err_address), 32'd0);
    model_eaddr = '0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    clear_obs();
    access(1'b0, 20'h40000, 8'h00, 16, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_sel_after", 32'(sel_or), 32'b1000);

    // 6: back-to-back reads with req held
    clear_obs();
    mem_rdata[7:0] = 8'h11;
    access(1'b0, 20'h00000, 8'h00, 1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_rdata[7:0] = 8'h22;
    access(1'b0, 20'h00001, 8'h00, 1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_err_pulses", 32'(err_pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
